// File: rtl/wave_buf_pkg.sv
// Shared constants and the FSM state encoding for the waveform capture buffer.
package wave_buf_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 10;
  localparam int DECIM_DEF  = 48;
  localparam int RD_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wave_buf_ram.sv
// Simple dual-port RAM with a registered read port; contents are not reset.
module wave_buf_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/wave_buf_reader.sv
// Circular capture buffer for decimated ADC samples; frozen contents are served
// oldest-first through a two-stage read pipeline.
module wave_buf_reader
  import wave_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DECIM  = DECIM_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WRITE_ON,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE_DATA,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_COL,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              FROZEN,
  output logic [ADDR_W:0]   FILL
);
  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]     DEC_LAST = 16'(DECIM - 1);

  logic won_m, won_s, won_d;
  logic won_rise, won_fall;
  wb_state_e state;
  logic [ADDR_W-1:0] wr_ptr, base;
  logic [15:0]       decim_cnt;
  logic              frozen_q;
  logic              we;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      won_m <= 1'b0;
      won_s <= 1'b0;
      won_d <= 1'b0;
    end else begin
      won_m <= WRITE_ON;
      won_s <= won_m;
      won_d <= won_s;
    end
  end

  assign won_rise = won_s & ~won_d;
  assign won_fall = ~won_s & won_d;

  // A strobe coinciding with the freeze event is dropped: freeze wins.
  assign we = (state == ST_CAPTURE) && SAMPLE_VALID && !won_fall && (decim_cnt == DEC_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      decim_cnt <= '0;
      FILL      <= '0;
      frozen_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (won_s) begin
          state     <= ST_CAPTURE;
          wr_ptr    <= '0;
          FILL      <= '0;
          decim_cnt <= '0;
        end
        ST_CAPTURE: begin
          if (won_fall) begin
            state    <= ST_FROZEN;
            frozen_q <= 1'b1;
            // Once wrapped, the oldest sample sits at the next write slot.
            base     <= (FILL == FILL_MAX) ? wr_ptr : '0;
          end else if (SAMPLE_VALID) begin
            if (decim_cnt == DEC_LAST) begin
              decim_cnt <= '0;
              wr_ptr    <= wr_ptr + 1'b1;
              if (FILL != FILL_MAX) FILL <= FILL + 1'b1;
            end else begin
              decim_cnt <= decim_cnt + 1'b1;
            end
          end
        end
        ST_FROZEN: if (won_rise) begin
          state     <= ST_CAPTURE;
          frozen_q  <= 1'b0;
          wr_ptr    <= '0;
          FILL      <= '0;
          decim_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign FROZEN = frozen_q;

  logic              rd_acc, rd_msk;
  logic [RD_LAT:1]   vld_pipe, msk_pipe;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;

  assign rd_acc = RD_REQ & frozen_q;
  assign rd_msk = ({1'b0, RD_COL} >= FILL);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_pipe <= '0;
      msk_pipe <= '0;
      rd_addr  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:1], rd_acc};
      msk_pipe <= {msk_pipe[RD_LAT-1:1], rd_msk};
      rd_addr  <= base + RD_COL;
    end
  end

  wave_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .CLK   (CLK),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (SAMPLE_DATA),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign RD_VALID = vld_pipe[RD_LAT];
  assign RD_DATA  = (vld_pipe[RD_LAT] && !msk_pipe[RD_LAT]) ? ram_q : '0;
endmodule
